// File: rtl/pad_trig_pkg.sv
// Shared types and default parameters for the pad trigger sequencer.
package pad_trig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMED  = 3'd1,
    ST_WINDOW = 3'd2,
    ST_TRIG   = 3'd3,
    ST_DEAD   = 3'd4
  } state_t;

  localparam int unsigned MAP_W      = 16;
  localparam int unsigned WIN_W_DEF  = 8;
  localparam int unsigned DEAD_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 16;

  localparam logic [MAP_W-1:0] MAP_RST_DEF = 16'h0000;

endpackage

// File: rtl/pad_trig_sat_counter.sv
// Saturating event counter with synchronous clear that wins over increment.
module pad_trig_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Count up on inc, stop at all-ones, clear to zero on clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pad_trigger_sequencer.sv
// Sequences the pad-hit coincidence window, owns the match map, and keeps
// trigger/timeout statistics.
module pad_trigger_sequencer
  import pad_trig_pkg::*;
#(
  parameter int unsigned      WIN_W   = WIN_W_DEF,
  parameter int unsigned      DEAD_W  = DEAD_W_DEF,
  parameter int unsigned      CNT_W   = CNT_W_DEF,
  parameter logic [MAP_W-1:0] MAP_RST = MAP_RST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run_en,
  input  logic              src_valid,
  input  logic              pad_hited_clear,
  input  logic              cfg_map_wr,
  input  logic [MAP_W-1:0]  cfg_map,
  input  logic [WIN_W-1:0]  cfg_window,
  input  logic [DEAD_W-1:0] cfg_dead,
  input  logic              cnt_clr,
  output logic              gen_data_valid,
  output logic [MAP_W-1:0]  pad_matched_map,
  output logic              map_pending,
  output logic              trigger_out,
  output logic              timeout_out,
  output logic              busy,
  output logic [CNT_W-1:0]  trig_count,
  output logic [CNT_W-1:0]  timeout_count
);

  state_t             state, state_nxt;
  logic [WIN_W-1:0]   win_cnt, win_cnt_nxt;
  logic [DEAD_W-1:0]  dead_cnt, dead_cnt_nxt;
  logic [WIN_W-1:0]   win_len;
  logic               win_last;
  logic               tmo_evt;
  logic               gdv_q;
  logic               apply_ok;
  logic [MAP_W-1:0]   pend_map;

  // A zero window length behaves as a single drain cycle.
  assign win_len  = (cfg_window == '0) ? WIN_W'(1) : cfg_window;
  assign win_last = (win_cnt == win_len);

  // Map may only change while the generator pipeline is provably empty.
  assign apply_ok = (state == ST_IDLE) ||
                    ((state == ST_ARMED) && !gen_data_valid && !gdv_q);

  // State, window/dead counters and registered pulse outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      win_cnt     <= '0;
      dead_cnt    <= '0;
      trigger_out <= 1'b0;
      timeout_out <= 1'b0;
      busy        <= 1'b0;
      gdv_q       <= 1'b0;
    end else begin
      state       <= state_nxt;
      win_cnt     <= win_cnt_nxt;
      dead_cnt    <= dead_cnt_nxt;
      trigger_out <= (state_nxt == ST_TRIG);
      timeout_out <= tmo_evt;
      busy        <= (state_nxt == ST_WINDOW) || (state_nxt == ST_TRIG) ||
                     (state_nxt == ST_DEAD);
      gdv_q       <= gen_data_valid;
    end
  end

  // Next-state, valid gating and timeout detection.
  always_comb begin
    state_nxt      = state;
    win_cnt_nxt    = win_cnt;
    dead_cnt_nxt   = dead_cnt;
    gen_data_valid = 1'b0;
    tmo_evt        = 1'b0;
    case (state)
      ST_IDLE: begin
        state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        gen_data_valid = src_valid;
        if (src_valid) begin
          state_nxt   = ST_WINDOW;
          win_cnt_nxt = WIN_W'(1);
        end
      end
      ST_WINDOW: begin
        gen_data_valid = src_valid && !win_last;
        if (pad_hited_clear) begin
          state_nxt = ST_TRIG;
        end else if (win_last) begin
          state_nxt = ST_ARMED;
          tmo_evt   = 1'b1;
        end else begin
          win_cnt_nxt = win_cnt + WIN_W'(1);
        end
      end
      ST_TRIG: begin
        if (cfg_dead == '0) begin
          state_nxt = ST_ARMED;
        end else begin
          state_nxt    = ST_DEAD;
          dead_cnt_nxt = cfg_dead;
        end
      end
      ST_DEAD: begin
        if (dead_cnt <= DEAD_W'(1)) begin
          state_nxt = ST_ARMED;
        end else begin
          dead_cnt_nxt = dead_cnt - DEAD_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    // Dropping run_en abandons any window without pulses.
    if (!run_en) begin
      state_nxt = ST_IDLE;
      tmo_evt   = 1'b0;
    end
  end

  // Pending-map capture and safe application to the generator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_matched_map <= MAP_RST;
      pend_map        <= MAP_RST;
      map_pending     <= 1'b0;
    end else if (cfg_map_wr && apply_ok) begin
      pad_matched_map <= cfg_map;
      map_pending     <= 1'b0;
    end else if (cfg_map_wr) begin
      pend_map        <= cfg_map;
      map_pending     <= 1'b1;
    end else if (apply_ok && map_pending) begin
      pad_matched_map <= pend_map;
      map_pending     <= 1'b0;
    end
  end

  pad_trig_sat_counter #(.W(CNT_W)) u_trig_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (trigger_out),
    .clr   (cnt_clr),
    .count (trig_count)
  );

  pad_trig_sat_counter #(.W(CNT_W)) u_tmo_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (timeout_out),
    .clr   (cnt_clr),
    .count (timeout_count)
  );

endmodule

// File: tb/tb_pad_trigger_sequencer.sv
// Directed bench for pad_trigger_sequencer; narrow counters make saturation reachable.
module tb_pad_trigger_sequencer;

  localparam int unsigned WIN_W  = 8;
  localparam int unsigned DEAD_W = 8;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              run_en;
  logic              src_valid;
  logic              pad_hited_clear;
  logic              cfg_map_wr;
  logic [15:0]       cfg_map;
  logic [WIN_W-1:0]  cfg_window;
  logic [DEAD_W-1:0] cfg_dead;
  logic              cnt_clr;
  logic              gen_data_valid;
  logic [15:0]       pad_matched_map;
  logic              map_pending;
  logic              trigger_out;
  logic              timeout_out;
  logic              busy;
  logic [CNT_W-1:0]  trig_count;
  logic [CNT_W-1:0]  timeout_count;

  int n_total = 0;
  int n_bad   = 0;

  pad_trigger_sequencer #(
    .WIN_W   (WIN_W),
    .DEAD_W  (DEAD_W),
    .CNT_W   (CNT_W),
    .MAP_RST (16'h0000)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .run_en          (run_en),
    .src_valid       (src_valid),
    .pad_hited_clear (pad_hited_clear),
    .cfg_map_wr      (cfg_map_wr),
    .cfg_map         (cfg_map),
    .cfg_window      (cfg_window),
    .cfg_dead        (cfg_dead),
    .cnt_clr         (cnt_clr),
    .gen_data_valid  (gen_data_valid),
    .pad_matched_map (pad_matched_map),
    .map_pending     (map_pending),
    .trigger_out     (trigger_out),
    .timeout_out     (timeout_out),
    .busy            (busy),
    .trig_count      (trig_count),
    .timeout_count   (timeout_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One W=1, D=0 trigger starting from ARMED; optional clear during the TRIG cycle.
  task automatic do_trig(input bit clr);
    src_valid = 1'b1;
    tick();
    src_valid = 1'b0;
    pad_hited_clear = 1'b1;
    tick();
    pad_hited_clear = 1'b0;
    cnt_clr = clr;
    chk("loop_trig_pulse", 32'(trigger_out), 32'd1);
    tick();
    cnt_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; run_en = 1'b0; src_valid = 1'b0; pad_hited_clear = 1'b0;
    cfg_map_wr = 1'b0; cfg_map = 16'h0; cfg_window = 8'd4; cfg_dead = 8'd3;
    cnt_clr = 1'b0;
    tick(); tick();
    src_valid = 1'b1;
    #1;
    chk("rst_gdv", 32'(gen_data_valid), 32'd0);
    chk("rst_map", 32'(pad_matched_map), 32'h0);
    chk("rst_pending", 32'(map_pending), 32'd0);
    chk("rst_trig", 32'(trigger_out), 32'd0);
    chk("rst_tmo", 32'(timeout_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_trig_cnt", 32'(trig_count), 32'd0);
    chk("rst_tmo_cnt", 32'(timeout_count), 32'd0);
    src_valid = 1'b0;

    // Hit path W=4 D=3, plus a map write during dead time.
    rst_n = 1'b1; run_en = 1'b1;
    tick();                                   // ARMED, t0
    chk("armed_busy", 32'(busy), 32'd0);
    src_valid = 1'b1;
    #1 chk("armed_gdv", 32'(gen_data_valid), 32'd1);
    tick();                                   // WINDOW 1
    src_valid = 1'b0;
    chk("win_busy", 32'(busy), 32'd1);
    tick();                                   // WINDOW 2, hit returns
    pad_hited_clear = 1'b1;
    tick();                                   // TRIG at t0+3
    pad_hited_clear = 1'b0;
    chk("hit_trig", 32'(trigger_out), 32'd1);
    src_valid = 1'b1;
    #1 chk("trig_gate", 32'(gen_data_valid), 32'd0);
    src_valid = 1'b0;
    tick();                                   // DEAD 3
    chk("trig_one_cycle", 32'(trigger_out), 32'd0);
    chk("trig_cnt_1", 32'(trig_count), 32'd1);
    cfg_map_wr = 1'b1; cfg_map = 16'h00F0;
    tick();                                   // DEAD 2
    cfg_map_wr = 1'b0;
    chk("dead_pending", 32'(map_pending), 32'd1);
    chk("dead_map_hold", 32'(pad_matched_map), 32'h0);
    tick();                                   // DEAD 1
    chk("dead_busy", 32'(busy), 32'd1);
    tick();                                   // ARMED at t0+7
    chk("rearm_busy", 32'(busy), 32'd0);
    chk("armed_map_hold", 32'(pad_matched_map), 32'h0);
    chk("armed_pending", 32'(map_pending), 32'd1);
    tick();
    chk("map_applied", 32'(pad_matched_map), 32'h00F0);
    chk("pending_clr", 32'(map_pending), 32'd0);

    // Timeout W=3.
    cfg_window = 8'd3;
    src_valid = 1'b1;
    #1 chk("w3_gdv_t0", 32'(gen_data_valid), 32'd1);
    tick();
    chk("w3_gdv_t1", 32'(gen_data_valid), 32'd1);
    tick();
    chk("w3_gdv_t2", 32'(gen_data_valid), 32'd1);
    tick();                                   // drain
    chk("w3_drain_gate", 32'(gen_data_valid), 32'd0);
    chk("w3_no_tmo_yet", 32'(timeout_out), 32'd0);
    src_valid = 1'b0;
    tick();
    chk("w3_tmo", 32'(timeout_out), 32'd1);
    chk("w3_tmo_busy", 32'(busy), 32'd0);
    tick();
    chk("w3_tmo_one", 32'(timeout_out), 32'd0);
    chk("tmo_cnt_1", 32'(timeout_count), 32'd1);

    // W=1 hit, D=0.
    cfg_window = 8'd1; cfg_dead = 8'd0;
    src_valid = 1'b1;
    tick();
    chk("w1_drain_gate", 32'(gen_data_valid), 32'd0);
    src_valid = 1'b0; pad_hited_clear = 1'b1;
    tick();
    pad_hited_clear = 1'b0;
    chk("w1_trig", 32'(trigger_out), 32'd1);
    tick();
    chk("d0_rearm", 32'(busy), 32'd0);
    chk("trig_cnt_2", 32'(trig_count), 32'd2);

    // W=0 no hit.
    cfg_window = 8'd0;
    src_valid = 1'b1;
    tick();
    chk("w0_drain_gate", 32'(gen_data_valid), 32'd0);
    src_valid = 1'b0;
    tick();
    chk("w0_tmo", 32'(timeout_out), 32'd1);
    tick();
    chk("tmo_cnt_2", 32'(timeout_count), 32'd2);

    // W=0 hit.
    src_valid = 1'b1;
    tick();
    src_valid = 1'b0; pad_hited_clear = 1'b1;
    tick();
    pad_hited_clear = 1'b0;
    chk("w0_trig", 32'(trigger_out), 32'd1);
    tick();
    chk("trig_cnt_3", 32'(trig_count), 32'd3);

    // W=1 no hit.
    cfg_window = 8'd1;
    src_valid = 1'b1;
    tick();
    src_valid = 1'b0;
    tick();
    chk("w1_tmo", 32'(timeout_out), 32'd1);
    tick();
    chk("tmo_cnt_3", 32'(timeout_count), 32'd3);

    // run_en drop mid-window with a hit due; map write while IDLE.
    cfg_window = 8'd4;
    src_valid = 1'b1;
    tick();                                   // WINDOW 1
    src_valid = 1'b0; run_en = 1'b0;
    tick();                                   // IDLE
    pad_hited_clear = 1'b1;
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_trig", 32'(trigger_out), 32'd0);
    cfg_map_wr = 1'b1; cfg_map = 16'hA5A5;
    tick();
    pad_hited_clear = 1'b0; cfg_map_wr = 1'b0;
    chk("drop_trig_late", 32'(trigger_out), 32'd0);
    chk("drop_tmo", 32'(timeout_out), 32'd0);
    chk("drop_trig_cnt", 32'(trig_count), 32'd3);
    chk("drop_tmo_cnt", 32'(timeout_count), 32'd3);
    chk("idle_map_direct", 32'(pad_matched_map), 32'hA5A5);
    chk("idle_pending", 32'(map_pending), 32'd0);

    // Saturation, then clear racing an increment.
    run_en = 1'b1; cfg_window = 8'd1; cfg_dead = 8'd0;
    tick();                                   // ARMED
    for (int i = 0; i < 12; i++) do_trig(1'b0);
    chk("trig_cnt_full", 32'(trig_count), 32'hF);
    do_trig(1'b0);
    chk("trig_cnt_sat", 32'(trig_count), 32'hF);
    do_trig(1'b1);
    chk("clr_wins_trig", 32'(trig_count), 32'd0);
    chk("clr_tmo_cnt", 32'(timeout_count), 32'd0);
    do_trig(1'b0);
    chk("trig_after_clr", 32'(trig_count), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
